// File: rtl/lbp_stream_engine.sv
// Single-pass Local Binary Pattern engine.
// The gray frame is read once in raster order; two line buffers plus a 3x3
// window give every interior centre its eight neighbours. One 8-bit code is
// written per centre, and finish goes high when the frame has been written.
// Optional feature macro: LBP_BORDER_WRITE_EN. When defined, border cells are
// also written with 8'h00, so every address of the frame is written in order.
module lbp_stream_engine #(
  parameter int IMG_W   = 128,
  parameter int IMG_H   = 128,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 14,
  parameter int THR_OFS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [PIX_W-1:0]  gray_data,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H + 1);
  localparam int C_W = $clog2(IMG_W + 3);
  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(IMG_W * IMG_H - 1);
`ifdef LBP_BORDER_WRITE_EN
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(IMG_W * IMG_H - 1);
`else
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'((IMG_H - 2) * IMG_W + IMG_W - 2);
`endif
  // Number of pipeline advances before the write address starts moving.
  localparam logic [C_W-1:0] WR_LAG = C_W'(IMG_W + 2);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t            state_r, state_next_s;
  logic              rd_acc_s, adv_s, wr_go_s, interior_s;
  logic [7:0]        code_s;
  logic [X_W-1:0]    rd_x_r, wr_x_r;
  logic [Y_W-1:0]    wr_y_r;
  logic [C_W-1:0]    adv_r;
  logic [ADDR_W-1:0] rd_addr_r, wr_addr_r, lbp_addr_r;
  logic [PIX_W-1:0]  lb0_r [IMG_W];
  logic [PIX_W-1:0]  lb1_r [IMG_W];
  logic [PIX_W-1:0]  win_r [9];
  logic [7:0]        lbp_data_r;
  logic              lbp_valid_r, finish_r;

  // Neighbour bit: set when the neighbour reaches centre plus offset (no overflow).
  function automatic logic nb_bit(input logic [PIX_W-1:0] g_k, input logic [PIX_W-1:0] g_c);
    logic [PIX_W:0] thr;
    thr = {1'b0, g_c} + (PIX_W + 1)'(THR_OFS);
    return ({1'b0, g_k} >= thr);
  endfunction

  // Next-state and per-cycle strobes: reads only while ready, drain freely in FLUSH.
  always_comb begin
    state_next_s = state_r;
    gray_req     = 1'b0;
    rd_acc_s     = 1'b0;
    adv_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (gray_ready) begin
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (gray_ready) begin
          gray_req = 1'b1;
          rd_acc_s = 1'b1;
          adv_s    = 1'b1;
          if (rd_addr_r == LAST_RD) begin
            state_next_s = FLUSH;
          end else begin
            state_next_s = READ;
          end
        end else begin
          state_next_s = READ;
        end
      end
      FLUSH: begin
        adv_s = 1'b1;
        if (lbp_valid_r && (lbp_addr_r == LAST_WR)) begin
          state_next_s = DONE;
        end else begin
          state_next_s = FLUSH;
        end
      end
      DONE: begin
        state_next_s = DONE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Write-side qualifiers and the LBP code of the current window centre.
  always_comb begin
    wr_go_s    = adv_s && (adv_r >= WR_LAG);
    interior_s = (wr_x_r >= X_W'(1)) && (wr_x_r <= X_W'(IMG_W - 2)) &&
                 (wr_y_r >= Y_W'(1)) && (wr_y_r <= Y_W'(IMG_H - 2));
    code_s = {nb_bit(win_r[8], win_r[4]), nb_bit(win_r[7], win_r[4]),
              nb_bit(win_r[6], win_r[4]), nb_bit(win_r[5], win_r[4]),
              nb_bit(win_r[3], win_r[4]), nb_bit(win_r[2], win_r[4]),
              nb_bit(win_r[1], win_r[4]), nb_bit(win_r[0], win_r[4])};
  end

  // Output drive; a pending write is shown only in a cycle where the pipeline advances.
  always_comb begin
    gray_addr = rd_addr_r;
    lbp_valid = lbp_valid_r & adv_s;
    lbp_addr  = lbp_addr_r;
    lbp_data  = lbp_data_r;
    finish    = finish_r;
  end

  // State register and sticky finish flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      finish_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      finish_r <= (state_next_s == DONE);
    end
  end

  // Read address and column counter; they hold while stalled and after the last read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr_r <= '0;
      rd_x_r    <= '0;
    end else if (rd_acc_s) begin
      rd_addr_r <= (rd_addr_r == LAST_RD) ? rd_addr_r : rd_addr_r + ADDR_W'(1);
      rd_x_r    <= (rd_x_r == X_W'(IMG_W - 1)) ? X_W'(0) : rd_x_r + X_W'(1);
    end else begin
      rd_addr_r <= rd_addr_r;
      rd_x_r    <= rd_x_r;
    end
  end

  // Line buffers and 3x3 window shift on every accepted read (top row = oldest line).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_r[i] <= '0;
        lb1_r[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= '0;
      end
    end else if (rd_acc_s) begin
      lb1_r[rd_x_r] <= lb0_r[rd_x_r];
      lb0_r[rd_x_r] <= gray_data;
      win_r[0] <= win_r[1];
      win_r[1] <= win_r[2];
      win_r[2] <= lb1_r[rd_x_r];
      win_r[3] <= win_r[4];
      win_r[4] <= win_r[5];
      win_r[5] <= lb0_r[rd_x_r];
      win_r[6] <= win_r[7];
      win_r[7] <= win_r[8];
      win_r[8] <= gray_data;
    end else begin
      win_r[0] <= win_r[0];
    end
  end

  // Write pipeline: the centre address trails the read stream by one line plus two pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adv_r       <= '0;
      wr_x_r      <= '0;
      wr_y_r      <= '0;
      wr_addr_r   <= '0;
      lbp_addr_r  <= '0;
      lbp_data_r  <= 8'h00;
      lbp_valid_r <= 1'b0;
    end else if (adv_s) begin
      adv_r      <= (adv_r < WR_LAG) ? adv_r + C_W'(1) : adv_r;
      lbp_addr_r <= wr_addr_r;
      lbp_data_r <= interior_s ? code_s : 8'h00;
`ifdef LBP_BORDER_WRITE_EN
      lbp_valid_r <= wr_go_s;
`else
      lbp_valid_r <= wr_go_s && interior_s;
`endif
      if (wr_go_s) begin
        wr_addr_r <= wr_addr_r + ADDR_W'(1);
        if (wr_x_r == X_W'(IMG_W - 1)) begin
          wr_x_r <= X_W'(0);
          wr_y_r <= wr_y_r + Y_W'(1);
        end else begin
          wr_x_r <= wr_x_r + X_W'(1);
        end
      end else begin
        wr_addr_r <= wr_addr_r;
      end
    end else begin
      lbp_valid_r <= lbp_valid_r;
    end
  end

endmodule
